// File: rtl/seq_matrix_multiply.sv
`default_nettype none
// ============================================================================
// Module   : seq_matrix_multiply
// Purpose  : C = A x B with one multiply-accumulate per clock, saturated to
//            RESULT_WIDTH, with a sticky per-operation overflow report.
// Revision : 1.0 - initial release
// ============================================================================
module seq_matrix_multiply #(
  parameter int ROWS_A       = 2,
  parameter int COLS_A       = 3,
  parameter int COLS_B       = 2,
  parameter int ELEM_WIDTH   = 14,
  parameter int RESULT_WIDTH = 28,
  parameter int SIGNED       = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [ROWS_A*COLS_A*ELEM_WIDTH-1:0]   A_in,
  input  logic [COLS_A*COLS_B*ELEM_WIDTH-1:0]   B_in,
  output logic [ROWS_A*COLS_B*RESULT_WIDTH-1:0] C_out,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overflow
);

  localparam int c_A_W   = ROWS_A * COLS_A * ELEM_WIDTH;
  localparam int c_B_W   = COLS_A * COLS_B * ELEM_WIDTH;
  localparam int c_C_W   = ROWS_A * COLS_B * RESULT_WIDTH;
  localparam int c_ACC_W = 2 * ELEM_WIDTH + $clog2(COLS_A) + 1;
  localparam int c_CMP_W = ((c_ACC_W > RESULT_WIDTH) ? c_ACC_W : RESULT_WIDTH) + 1;
  localparam int c_IW    = (ROWS_A > 1) ? $clog2(ROWS_A) : 1;
  localparam int c_JW    = (COLS_B > 1) ? $clog2(COLS_B) : 1;
  localparam int c_KW    = (COLS_A > 1) ? $clog2(COLS_A) : 1;

  localparam logic [c_IW-1:0] c_I_LAST = c_IW'(ROWS_A - 1);
  localparam logic [c_JW-1:0] c_J_LAST = c_JW'(COLS_B - 1);
  localparam logic [c_KW-1:0] c_K_LAST = c_KW'(COLS_A - 1);

  // Clamp bounds are held one bit wider than both the accumulator and the
  // result so the comparisons never wrap for any parameter combination.
  localparam logic signed [c_CMP_W-1:0] c_ONE  = c_CMP_W'(1);
  localparam logic signed [c_CMP_W-1:0] c_SMAX = (c_ONE <<< (RESULT_WIDTH - 1)) - c_ONE;
  localparam logic signed [c_CMP_W-1:0] c_SMIN = -(c_ONE <<< (RESULT_WIDTH - 1));
  localparam logic signed [c_CMP_W-1:0] c_UMAX = (c_ONE <<< RESULT_WIDTH) - c_ONE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                     r_state;
  logic [c_A_W-1:0]           r_a;
  logic [c_B_W-1:0]           r_b;
  logic [c_C_W-1:0]           r_buf;
  logic signed [c_ACC_W-1:0]  r_acc;
  logic                       r_ovf;
  logic [c_IW-1:0]            r_i;
  logic [c_JW-1:0]            r_j;
  logic [c_KW-1:0]            r_k;

  int                         w_a_off;
  int                         w_b_off;
  int                         w_c_off;
  logic [ELEM_WIDTH-1:0]      w_a_elem;
  logic [ELEM_WIDTH-1:0]      w_b_elem;
  logic signed [c_ACC_W-1:0]  w_a_ext;
  logic signed [c_ACC_W-1:0]  w_b_ext;
  logic signed [c_ACC_W-1:0]  w_sum;
  logic signed [c_CMP_W-1:0]  w_sum_ext;
  logic [RESULT_WIDTH-1:0]    w_sat;
  logic                       w_clamp;

  always_comb begin
    w_a_off  = (int'(r_i) * COLS_A + int'(r_k)) * ELEM_WIDTH;
    w_b_off  = (int'(r_k) * COLS_B + int'(r_j)) * ELEM_WIDTH;
    w_c_off  = (int'(r_i) * COLS_B + int'(r_j)) * RESULT_WIDTH;
    w_a_elem = r_a[w_a_off +: ELEM_WIDTH];
    w_b_elem = r_b[w_b_off +: ELEM_WIDTH];
  end

  generate
    if (SIGNED != 0) begin : g_signed_ext
      assign w_a_ext = c_ACC_W'(signed'(w_a_elem));
      assign w_b_ext = c_ACC_W'(signed'(w_b_elem));
    end else begin : g_unsigned_ext
      assign w_a_ext = c_ACC_W'(w_a_elem);
      assign w_b_ext = c_ACC_W'(w_b_elem);
    end
  endgenerate

  // Accumulator width covers the full K-term sum, so the low bits of the
  // signed product are exact in both modes.
  assign w_sum     = r_acc + w_a_ext * w_b_ext;
  assign w_sum_ext = c_CMP_W'(w_sum);

  always_comb begin
    w_sat   = w_sum_ext[RESULT_WIDTH-1:0];
    w_clamp = 1'b0;
    if (SIGNED != 0) begin
      if (w_sum_ext > c_SMAX) begin
        w_sat   = c_SMAX[RESULT_WIDTH-1:0];
        w_clamp = 1'b1;
      end else if (w_sum_ext < c_SMIN) begin
        w_sat   = c_SMIN[RESULT_WIDTH-1:0];
        w_clamp = 1'b1;
      end
    end else begin
      if (w_sum_ext[c_CMP_W-1]) begin
        w_sat   = '0;
        w_clamp = 1'b1;
      end else if (w_sum_ext > c_UMAX) begin
        w_sat   = c_UMAX[RESULT_WIDTH-1:0];
        w_clamp = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_buf    <= '0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      C_out    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= A_in;
            r_b     <= B_in;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          if (r_k == c_K_LAST) begin
            r_buf[w_c_off +: RESULT_WIDTH] <= w_sat;
            r_acc <= '0;
            r_ovf <= r_ovf | w_clamp;
            r_k   <= '0;
            if (r_j == c_J_LAST) begin
              r_j <= '0;
              if (r_i == c_I_LAST) begin
                r_i     <= '0;
                r_state <= S_DONE;
              end else begin
                r_i <= r_i + 1'b1;
              end
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_acc <= w_sum;
            r_k   <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          C_out    <= r_buf;
          overflow <= r_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_matrix_multiply.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_matrix_multiply
// Purpose  : Directed self-checking bench over four parameterisations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_matrix_multiply;

  logic clk;
  logic rst_n;
  int   nchk;
  int   nfail;

  // u0: defaults 2x3x2 unsigned
  logic         start0;
  logic [83:0]  A0;
  logic [83:0]  B0;
  logic [111:0] C0;
  logic         busy0, done0, ovf0;
  // u1: 2x3x1 unsigned
  logic         start1;
  logic [83:0]  A1;
  logic [41:0]  B1;
  logic [55:0]  C1;
  logic         busy1, done1, ovf1;
  // u2: 2x2x2 signed, 8-bit elements
  logic         start2;
  logic [31:0]  A2;
  logic [31:0]  B2;
  logic [111:0] C2;
  logic         busy2, done2, ovf2;
  // u3: 1x2x1 signed, 8-bit elements and results
  logic         start3;
  logic [15:0]  A3;
  logic [15:0]  B3;
  logic [7:0]   C3;
  logic         busy3, done3, ovf3;

  seq_matrix_multiply u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .A_in(A0), .B_in(B0),
    .C_out(C0), .busy(busy0), .done(done0), .overflow(ovf0));

  seq_matrix_multiply #(.COLS_B(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A_in(A1), .B_in(B1),
    .C_out(C1), .busy(busy1), .done(done1), .overflow(ovf1));

  seq_matrix_multiply #(.ROWS_A(2), .COLS_A(2), .COLS_B(2), .ELEM_WIDTH(8),
                        .RESULT_WIDTH(28), .SIGNED(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .A_in(A2), .B_in(B2),
    .C_out(C2), .busy(busy2), .done(done2), .overflow(ovf2));

  seq_matrix_multiply #(.ROWS_A(1), .COLS_A(2), .COLS_B(1), .ELEM_WIDTH(8),
                        .RESULT_WIDTH(8), .SIGNED(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .A_in(A3), .B_in(B3),
    .C_out(C3), .busy(busy3), .done(done3), .overflow(ovf3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic load_xtx();
    int a[6] = '{1, 1, 1, 2, 5, 8};
    int b[6] = '{1, 2, 1, 5, 1, 8};
    for (int n = 0; n < 6; n++) begin
      A0[n*14 +: 14] = 14'(a[n]);
      B0[n*14 +: 14] = 14'(b[n]);
    end
  endtask

  // Edge count includes the accepting edge; busy is tallied per cycle until done.
  task automatic run0(output int edges, output int bcyc);
    edges = 0; bcyc = 0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; edges = 1; start0 = 1'b0;
    while (!done0 && edges < 200) begin
      bcyc += int'(busy0);
      @(posedge clk); #1; edges++;
    end
  endtask

  task automatic run1(output int edges);
    edges = 0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; edges = 1; start1 = 1'b0;
    while (!done1 && edges < 200) begin
      @(posedge clk); #1; edges++;
    end
  endtask

  task automatic run2(output int edges);
    edges = 0;
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; edges = 1; start2 = 1'b0;
    while (!done2 && edges < 200) begin
      @(posedge clk); #1; edges++;
    end
  endtask

  task automatic run3(output int edges);
    edges = 0;
    @(negedge clk); start3 = 1'b1;
    @(posedge clk); #1; edges = 1; start3 = 1'b0;
    while (!done3 && edges < 200) begin
      @(posedge clk); #1; edges++;
    end
  endtask

  task automatic test_reset();
    nchk++; if (C0 !== '0)   begin nfail++; $display("FAIL reset_c got=%h exp=0", C0); end
    nchk++; if (busy0 !== 0) begin nfail++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    nchk++; if (done0 !== 0) begin nfail++; $display("FAIL reset_done got=%b exp=0", done0); end
    nchk++; if (ovf0 !== 0)  begin nfail++; $display("FAIL reset_ovf got=%b exp=0", ovf0); end
  endtask

  task automatic test_xtx();
    int e[4] = '{3, 15, 15, 93};
    int edges, bcyc;
    load_xtx();
    run0(edges, bcyc);
    nchk++; if (edges != 14) begin nfail++; $display("FAIL xtx_latency got=%0d exp=14", edges); end
    nchk++; if (bcyc != 13)  begin nfail++; $display("FAIL xtx_busy_cycles got=%0d exp=13", bcyc); end
    nchk++; if (busy0 !== 0) begin nfail++; $display("FAIL xtx_busy_at_done got=%b exp=0", busy0); end
    for (int n = 0; n < 4; n++) begin
      nchk++;
      if (C0[n*28 +: 28] !== 28'(e[n])) begin
        nfail++; $display("FAIL xtx_c%0d got=%0d exp=%0d", n, C0[n*28 +: 28], e[n]);
      end
    end
    nchk++; if (ovf0 !== 0) begin nfail++; $display("FAIL xtx_ovf got=%b exp=0", ovf0); end
    @(posedge clk); #1;
    nchk++; if (done0 !== 0) begin nfail++; $display("FAIL xtx_done_pulse got=%b exp=0", done0); end
  endtask

  task automatic test_xty();
    int a[6] = '{1, 1, 1, 2, 5, 8};
    int b[3] = '{3, 6, 9};
    int e[2] = '{18, 108};
    int edges;
    for (int n = 0; n < 6; n++) A1[n*14 +: 14] = 14'(a[n]);
    for (int n = 0; n < 3; n++) B1[n*14 +: 14] = 14'(b[n]);
    run1(edges);
    nchk++; if (edges != 8) begin nfail++; $display("FAIL xty_latency got=%0d exp=8", edges); end
    for (int n = 0; n < 2; n++) begin
      nchk++;
      if (C1[n*28 +: 28] !== 28'(e[n])) begin
        nfail++; $display("FAIL xty_c%0d got=%0d exp=%0d", n, C1[n*28 +: 28], e[n]);
      end
    end
    nchk++; if (ovf1 !== 0) begin nfail++; $display("FAIL xty_ovf got=%b exp=0", ovf1); end
  endtask

  task automatic test_signed();
    int a[4] = '{-1, 2, 3, -4};
    int b[4] = '{5, -6, 7, 8};
    int e[4] = '{9, 22, -13, -50};
    int edges;
    for (int n = 0; n < 4; n++) begin
      A2[n*8 +: 8] = 8'(a[n]);
      B2[n*8 +: 8] = 8'(b[n]);
    end
    run2(edges);
    nchk++; if (edges != 10) begin nfail++; $display("FAIL signed_latency got=%0d exp=10", edges); end
    for (int n = 0; n < 4; n++) begin
      nchk++;
      if (C2[n*28 +: 28] !== 28'(e[n])) begin
        nfail++; $display("FAIL signed_c%0d got=%h exp=%h", n, C2[n*28 +: 28], 28'(e[n]));
      end
    end
    nchk++; if (ovf2 !== 0) begin nfail++; $display("FAIL signed_ovf got=%b exp=0", ovf2); end
  endtask

  task automatic test_saturation();
    int edges;
    A3 = {8'd100, 8'd100};
    B3 = {8'hFF, 8'd100};
    run3(edges);
    nchk++; if (C3 !== 8'd127) begin nfail++; $display("FAIL sat_c got=%0d exp=127", C3); end
    nchk++; if (ovf3 !== 1)    begin nfail++; $display("FAIL sat_ovf got=%b exp=1", ovf3); end
    A3 = {8'd0, 8'd5};
    B3 = {8'd0, 8'd1};
    run3(edges);
    nchk++; if (C3 !== 8'd5) begin nfail++; $display("FAIL sat_follow_c got=%0d exp=5", C3); end
    nchk++; if (ovf3 !== 0)  begin nfail++; $display("FAIL sat_follow_ovf got=%b exp=0", ovf3); end
  endtask

  task automatic test_ignored_start();
    int e[4] = '{3, 15, 15, 93};
    int edges, dcnt, bcnt;
    load_xtx();
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; edges = 1; start0 = 1'b0;
    while (!done0 && edges < 200) begin
      if (edges == 5) begin start0 = 1'b1; A0 = {84{1'b1}}; end
      if (edges == 6) start0 = 1'b0;
      @(posedge clk); #1; edges++;
    end
    nchk++; if (edges != 14) begin nfail++; $display("FAIL ign_latency got=%0d exp=14", edges); end
    for (int n = 0; n < 4; n++) begin
      nchk++;
      if (C0[n*28 +: 28] !== 28'(e[n])) begin
        nfail++; $display("FAIL ign_c%0d got=%0d exp=%0d", n, C0[n*28 +: 28], e[n]);
      end
    end
    dcnt = 0; bcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      dcnt += int'(done0);
      bcnt += int'(busy0);
    end
    nchk++; if (dcnt != 0) begin nfail++; $display("FAIL ign_extra_done got=%0d exp=0", dcnt); end
    nchk++; if (bcnt != 0) begin nfail++; $display("FAIL ign_extra_busy got=%0d exp=0", bcnt); end
    load_xtx();
  endtask

  task automatic test_back_to_back();
    int e[4] = '{3, 15, 15, 93};
    int edges;
    edges = 0;
    @(negedge clk); start0 = 1'b1;
    while (!done0 && edges < 200) begin
      @(posedge clk); #1; edges++;
    end
    edges = 0;
    do begin
      @(posedge clk); #1; edges++;
      if (busy0 && done0) begin
        nchk++; nfail++; $display("FAIL b2b_busy_done_overlap got=1 exp=0");
      end
    end while (!done0 && edges < 200);
    start0 = 1'b0;
    nchk++; if (edges != 14) begin nfail++; $display("FAIL b2b_interval got=%0d exp=14", edges); end
    for (int n = 0; n < 4; n++) begin
      nchk++;
      if (C0[n*28 +: 28] !== 28'(e[n])) begin
        nfail++; $display("FAIL b2b_c%0d got=%0d exp=%0d", n, C0[n*28 +: 28], e[n]);
      end
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    int e[4] = '{3, 15, 15, 93};
    int edges, bcyc, dcnt;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    nchk++; if (busy0 !== 0) begin nfail++; $display("FAIL rst_busy got=%b exp=0", busy0); end
    nchk++; if (C0 !== '0)   begin nfail++; $display("FAIL rst_c got=%h exp=0", C0); end
    nchk++; if (done0 !== 0) begin nfail++; $display("FAIL rst_done got=%b exp=0", done0); end
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      dcnt += int'(done0);
    end
    nchk++; if (dcnt != 0) begin nfail++; $display("FAIL rst_no_done got=%0d exp=0", dcnt); end
    run0(edges, bcyc);
    nchk++; if (edges != 14) begin nfail++; $display("FAIL rst_rerun_latency got=%0d exp=14", edges); end
    for (int n = 0; n < 4; n++) begin
      nchk++;
      if (C0[n*28 +: 28] !== 28'(e[n])) begin
        nfail++; $display("FAIL rst_rerun_c%0d got=%0d exp=%0d", n, C0[n*28 +: 28], e[n]);
      end
    end
  endtask

  initial begin
    nchk = 0; nfail = 0;
    rst_n = 1'b0;
    start0 = 0; start1 = 0; start2 = 0; start3 = 0;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    A2 = '0; B2 = '0; A3 = '0; B3 = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_xtx();
    test_xty();
    test_signed();
    test_saturation();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
